// File: rtl/vdf_sq_sequencer.sv
// vdf_sq_sequencer
//   Drives the polynomial modular squarer T times back-to-back. The start
//   value goes to the squarer first. Each squarer result is registered and
//   fed back as the next operand. After the last squaring the value is
//   offered on a valid/ready result port.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start_val/o_start_rdy      job handshake (ready only in IDLE)
//   i_start_dat, i_iter          initial value (redundant form), squaring count T
//   i_abort                      cancel the running job
//   o_mul_val/o_mul_dat          one-cycle issue pulse and registered operand
//   o_mul_reduce_only            held low (square mode only)
//   i_mul_val/i_mul_dat          squarer result
//   o_res_val/i_res_rdy/o_res_dat  final result handshake
//   o_iter_cnt                   squarings completed in the current/last job
//   o_busy                       not IDLE
//   o_err                        sticky: watchdog expiry or stray squarer result
module vdf_sq_sequencer #(
  parameter int I_WORD       = 5,
  parameter int COEF_BITS    = 9,
  parameter int CNT_BITS     = 32,
  parameter int MULT_LATENCY = 6,
  parameter int WDOG_SLACK   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start_val,
  output logic                          o_start_rdy,
  input  logic [I_WORD*COEF_BITS-1:0]   i_start_dat,
  input  logic [CNT_BITS-1:0]           i_iter,
  input  logic                          i_abort,
  output logic                          o_mul_val,
  output logic                          o_mul_reduce_only,
  output logic [I_WORD*COEF_BITS-1:0]   o_mul_dat,
  input  logic                          i_mul_val,
  input  logic [I_WORD*COEF_BITS-1:0]   i_mul_dat,
  output logic                          o_res_val,
  input  logic                          i_res_rdy,
  output logic [I_WORD*COEF_BITS-1:0]   o_res_dat,
  output logic [CNT_BITS-1:0]           o_iter_cnt,
  output logic                          o_busy,
  output logic                          o_err
);

  localparam int DAT_W  = I_WORD * COEF_BITS;
  localparam int WD_LIM = MULT_LATENCY + WDOG_SLACK;
  localparam int WD_W   = $clog2(WD_LIM + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] rem, rem_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic [DAT_W-1:0]    mul_dat, mul_dat_nxt;
  logic [DAT_W-1:0]    res_dat, res_dat_nxt;
  logic [WD_W-1:0]     wd, wd_nxt;
  logic                err, err_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      rem     <= '0;
      cnt     <= '0;
      mul_dat <= '0;
      res_dat <= '0;
      wd      <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      rem     <= rem_nxt;
      cnt     <= cnt_nxt;
      mul_dat <= mul_dat_nxt;
      res_dat <= res_dat_nxt;
      wd      <= wd_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem;
    cnt_nxt     = cnt;
    mul_dat_nxt = mul_dat;
    res_dat_nxt = res_dat;
    wd_nxt      = wd;
    err_nxt     = err;

    case (state)
      IDLE: begin
        if (i_start_val) begin
          rem_nxt     = i_iter;
          cnt_nxt     = '0;
          mul_dat_nxt = i_start_dat;
          res_dat_nxt = i_start_dat;
          err_nxt     = 1'b0;
          state_nxt   = (i_iter == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (i_abort) begin
          state_nxt = IDLE;
        end else begin
          // wd counts cycles elapsed since the issue cycle.
          wd_nxt    = WD_W'(1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_abort) begin
          // Abort takes priority over a result landing in the same cycle.
          state_nxt = IDLE;
        end else if (i_mul_val) begin
          mul_dat_nxt = i_mul_dat;
          res_dat_nxt = i_mul_dat;
          rem_nxt     = rem - CNT_BITS'(1);
          cnt_nxt     = cnt + CNT_BITS'(1);
          state_nxt   = (rem == CNT_BITS'(1)) ? DONE : ISSUE;
        end else if (wd == WD_W'(WD_LIM - 1)) begin
          // Last permitted wait cycle passed with no result: IDLE lands
          // exactly WD_LIM cycles after the issue.
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wd_nxt = wd + WD_W'(1);
        end
      end
      DONE: begin
        if (i_abort || i_res_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A squarer result outside WAIT has no owner; flag it and drop it.
    if (i_mul_val && (state != WAIT)) err_nxt = 1'b1;
  end

  assign o_start_rdy       = (state == IDLE);
  assign o_busy            = (state != IDLE);
  assign o_mul_val         = (state == ISSUE);
  assign o_res_val         = (state == DONE);
  assign o_mul_reduce_only = 1'b0;
  assign o_mul_dat         = mul_dat;
  assign o_res_dat         = res_dat;
  assign o_iter_cnt        = cnt;
  assign o_err             = err;

endmodule

// File: doc/vdf_sq_sequencer.md
# vdf_sq_sequencer

Iteration controller for the polynomial modular squarer in the VDF datapath. It accepts a start value and an iteration count T, then drives the squarer T times back-to-back. Each squarer output is registered and fed back as the next input. After the last iteration it presents the result on a valid/ready output port. It sits between the host-facing job interface and the squarer; the squarer is run with its multiply/square input (`i_dat_a`) and its `i_reduce_only` input held low.

## Interface
- `I_WORD`, default 5: coefficient words per operand; matches the squarer's `NUM_WORDS+1`.
- `COEF_BITS`, default 9: bits per redundant coefficient.
- `CNT_BITS`, default 32: width of the iteration count.
- `MULT_LATENCY`, default 6: cycles from squarer `i_val` to squarer `o_val`.
- `WDOG_SLACK`, default 4: extra wait cycles allowed before a timeout is declared.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start_val`  in  1  job request.
- `o_start_rdy`  out  1  high only in IDLE.
- `i_start_dat`  in  I_WORD*COEF_BITS  initial value, redundant form.
- `i_iter`  in  CNT_BITS  number of squarings T.
- `i_abort`  in  1  cancel the current job.
- `o_mul_val`  out  1  single-cycle issue pulse to the squarer.
- `o_mul_reduce_only`  out  1  tied 0.
- `o_mul_dat`  out  I_WORD*COEF_BITS  squarer operand, registered.
- `i_mul_val`  in  1  squarer result valid.
- `i_mul_dat`  in  I_WORD*COEF_BITS  squarer result.
- `o_res_val`  out  1  result valid.
- `i_res_rdy`  in  1  result accepted.
- `o_res_dat`  out  I_WORD*COEF_BITS  final value.
- `o_iter_cnt`  out  CNT_BITS  completed squarings for the current or last job.
- `o_busy`  out  1  state is not IDLE.
- `o_err`  out  1  sticky error; cleared only by reset or by an accepted start.

## Operation
States and transitions:
- **IDLE**
  - A start is accepted when `i_start_val & o_start_rdy`.
  - On accept: latch `i_iter` into `rem`, load `o_mul_dat`/`o_res_dat` with `i_start_dat`, clear `o_iter_cnt` and `o_err`.
  - If `i_iter==0`, go to DONE; otherwise go to ISSUE.
- **ISSUE**
  - Assert `o_mul_val` for exactly one cycle, start the watchdog counter, go to WAIT.
- **WAIT**
  - On `i_mul_val`: register `i_mul_dat` into both `o_mul_dat` and `o_res_dat`, decrement `rem`, increment `o_iter_cnt`.
  - If the new `rem==0`, go to DONE; otherwise go to ISSUE.
- **DONE**
  - `o_res_val=1`, and it stays high until `i_res_rdy`.
  - On handshake, go to IDLE.
  - `o_res_dat` is stable while `o_res_val=1 & !i_res_rdy`.

Error and abort behaviour:
- **Watchdog:** in WAIT, if `MULT_LATENCY+WDOG_SLACK` cycles elapse since issue without `i_mul_val`, set `o_err` and go to IDLE. No result is produced.
- **Spurious result:** `i_mul_val` in any state other than WAIT sets `o_err` and is otherwise ignored; the state is unchanged.
- **Abort:** `i_abort` in ISSUE, WAIT or DONE forces IDLE the next cycle. `o_res_val` drops and `o_err` is unchanged.
  - A squarer result arriving after an abort is a spurious result: it sets `o_err`, which is expected.
  - `i_abort` in IDLE has no effect.
  - If `i_abort` and `i_mul_val` are both asserted in WAIT, abort wins and the data is not captured.
- **Start while busy:** `i_start_val` outside IDLE is ignored, because `o_start_rdy=0`.
- **Count width:** `rem` and `o_iter_cnt` are CNT_BITS wide and do not wrap, since `o_iter_cnt` never exceeds `i_iter`.

## Timing
- **Reset values:**
  - state IDLE;
  - `o_start_rdy=1`;
  - `o_mul_val=0`, `o_mul_reduce_only=0`, `o_mul_dat=0`;
  - `o_res_val=0`, `o_res_dat=0`;
  - `o_iter_cnt=0`, `o_busy=0`, `o_err=0`.
- Reset mid-job returns to the reset values on the next edge. Squarer results that arrive afterwards set `o_err`.
- **Start and issue:** with a start accepted at edge N, the first `o_mul_val` is high in cycle N+1.
- **Per-iteration period:** MULT_LATENCY+1 cycles. The result is captured at issue+MULT_LATENCY, and the next issue follows one cycle later.
- **Result latency:** `o_res_val` first high in cycle N+1+T*(MULT_LATENCY+1) for T≥1, and in cycle N+1 for T=0.
- **Next start:** `o_start_rdy` returns high in the cycle after the result handshake.
- **Issue spacing:** `o_mul_val` is never high in two consecutive cycles.
- **Busy:** `o_busy` is high from N+1 until the return to IDLE.

## Test plan
- **T=3:** squarer model with L=6 computing (x²) mod 2^32; start at N=10, `i_start_dat=3`, `i_iter=3`. Required:
  - `o_mul_val` in cycles 11, 18 and 25;
  - `o_res_val` in cycle 32 with `o_res_dat=6561`;
  - `o_iter_cnt=3`.
- **T=0:** `i_start_dat=0x55`, `i_iter=0`. Required: `o_res_val` one cycle after accept with data 0x55, and `o_mul_val` never asserted.
- **Result backpressure:** `i_res_rdy` held low for 20 cycles. Required: `o_res_val` and `o_res_dat` hold steadily; IDLE is reached the cycle after `i_res_rdy` rises; `o_start_rdy=1`.
- **Abort:** `i_abort` asserted in the cycle of the 2nd `i_mul_val` of a T=5 job. Required:
  - IDLE on the next cycle;
  - `o_iter_cnt=1`;
  - no `o_res_val`;
  - `o_err=0`.
- **Timeout:** squarer model drops the response. Required: `o_err=1` and IDLE at issue+10 cycles; the next accepted start clears `o_err`.
- **Stray result and reset:** `i_mul_val` pulsed in IDLE sets `o_err`. `i_rst` asserted in WAIT forces all outputs to their reset values on the next edge.
